// File: rtl/rng_stream.sv
// rng_stream: packs a raw entropy byte stream into 32-bit little-endian words
// and sends them out as an AXI4-Stream master. The stream can end with a
// TLAST beat on a byte limit or a stop pulse, and can also carry periodic
// TLAST packet boundaries.
//
// Optional feature: define RNG_SUM_EN to build the RNG_SUM_DATA running byte
// sum. Without it RNG_SUM_DATA is tied to zero and no adder is built.
//
// Data path: byte -> packer (up to 3 bytes) -> hold register (one complete
// word) -> output FIFO {last, keep, data} -> AXIS outputs.
// The hold register delays each complete word until the next byte arrives.
// This lets the final word of a run be tagged with TLAST when the run ends.

module rng_stream #(
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic        AXIS_ACLK,
    input  logic        AXIS_ARESETN,
    input  logic        RNG_GO,
    input  logic        RNG_STOP,
    input  logic [31:0] RNG_SEND_BYTES,
    input  logic [31:0] RNG_DMA_BYTES,
    input  logic        RAW_VALID,
    input  logic [7:0]  RAW_DATA,
    output logic        RNG_RUN,
    output logic        RNG_OVER,
    output logic [31:0] RNG_SENT_BYTES,
    output logic [31:0] RNG_SUM_DATA,
    output logic [31:0] AXIS_TDATA,
    output logic [3:0]  AXIS_TKEEP,
    output logic        AXIS_TLAST,
    output logic        AXIS_TVALID,
    input  logic        AXIS_TREADY
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] PTR_ONE = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } entry_t;

    // Mask of the low n bytes of a partial word.
    function automatic logic [3:0] low_mask(input logic [1:0] n);
        logic [3:0] m;
        case (n)
            2'd1:    m = 4'b0001;
            2'd2:    m = 4'b0011;
            2'd3:    m = 4'b0111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Number of valid bytes in a beat.
    function automatic logic [2:0] keep_bytes(input logic [3:0] k);
        return {2'b00, k[0]} + {2'b00, k[1]} + {2'b00, k[2]} + {2'b00, k[3]};
    endfunction

    state_t state;
    state_t next_state;

    entry_t                   fifo_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2:0] rd_ptr;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     fifo_one;
    entry_t                   head;

    logic [31:0] pack_data;
    logic [1:0]  pack_cnt;
    logic        hold_valid;
    logic [31:0] hold_data;
    logic [31:0] acc_cnt;
    logic [31:0] pkt_cnt;
    logic        over_q;
    logic [31:0] sent_q;

    logic        go_accepted;
    logic        pop;
    logic        accept;
    logic        push;
    logic        final_push;
    logic        overflow;
    entry_t      push_entry;
    logic [31:0] packed_word;
    logic [31:0] acc_next;
    logic [31:0] pkt_next;
    logic        dma_hit;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]) &&
                        (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]);
    assign fifo_one   = ((wr_ptr - rd_ptr) == PTR_ONE);
    assign head       = fifo_mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];

    assign AXIS_TVALID = !fifo_empty;
    assign AXIS_TDATA  = fifo_empty ? 32'h0 : head.data;
    assign AXIS_TKEEP  = fifo_empty ? 4'h0  : head.keep;
    assign AXIS_TLAST  = fifo_empty ? 1'b0  : head.last;

    assign pop         = AXIS_TVALID && AXIS_TREADY;
    assign go_accepted = (state == IDLE) && RNG_GO && !RNG_STOP;

    assign packed_word = pack_data | ({24'h0, RAW_DATA} << {pack_cnt, 3'b000});
    assign acc_next    = acc_cnt + 32'd1;
    assign pkt_next    = pkt_cnt + 32'd4;
    assign dma_hit     = (RNG_DMA_BYTES != 32'd0) && (pkt_next >= RNG_DMA_BYTES);

    assign RNG_RUN        = (state != IDLE);
    assign RNG_OVER       = over_q;
    assign RNG_SENT_BYTES = sent_q;

    // State register.
    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Decide the next state and which byte, push, or overflow events happen this cycle.
    always_comb begin
        next_state      = state;
        accept          = 1'b0;
        push            = 1'b0;
        final_push      = 1'b0;
        overflow        = 1'b0;
        push_entry      = '0;
        case (state)
            IDLE: begin
                if (go_accepted) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (RNG_STOP) begin
                    next_state = (acc_cnt == 32'd0) ? IDLE : FLUSH;
                end else if (RAW_VALID) begin
                    if (hold_valid && fifo_full && !pop) begin
                        overflow = 1'b1;
                    end else begin
                        accept = 1'b1;
                        if (hold_valid) begin
                            push            = 1'b1;
                            push_entry.last = dma_hit;
                            push_entry.keep = 4'hF;
                            push_entry.data = hold_data;
                        end
                        if ((RNG_SEND_BYTES != 32'd0) && (acc_next == RNG_SEND_BYTES)) begin
                            next_state = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (hold_valid || (pack_cnt != 2'd0)) begin
                    if (!fifo_full || pop) begin
                        push            = 1'b1;
                        final_push      = 1'b1;
                        push_entry.last = 1'b1;
                        push_entry.keep = hold_valid ? 4'hF : low_mask(pack_cnt);
                        push_entry.data = hold_valid ? hold_data : pack_data;
                    end
                end else if (fifo_empty || (pop && fifo_one)) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Write pushed words into FIFO storage. The storage needs no reset because the pointers gate it.
    always_ff @(posedge AXIS_ACLK) begin
        if (push) begin
            fifo_mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= push_entry;
        end
    end

    // Update the FIFO pointers, packer, hold register, counters and status flags.
    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pack_data  <= '0;
            pack_cnt   <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            acc_cnt    <= '0;
            pkt_cnt    <= '0;
            over_q     <= 1'b0;
            sent_q     <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                sent_q <= sent_q + {29'h0, keep_bytes(head.keep)};
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (overflow) begin
                over_q <= 1'b1;
            end
            if (accept) begin
                acc_cnt <= acc_next;
                if (hold_valid) begin
                    hold_valid <= 1'b0;
                    pkt_cnt    <= dma_hit ? 32'd0 : pkt_next;
                end
                if (pack_cnt == 2'd3) begin
                    hold_data  <= packed_word;
                    hold_valid <= 1'b1;
                    pack_data  <= '0;
                    pack_cnt   <= '0;
                end else begin
                    pack_data <= packed_word;
                    pack_cnt  <= pack_cnt + 2'd1;
                end
            end
            if (final_push) begin
                hold_valid <= 1'b0;
                pack_data  <= '0;
                pack_cnt   <= '0;
                pkt_cnt    <= '0;
            end
            if (go_accepted) begin
                pack_data  <= '0;
                pack_cnt   <= '0;
                hold_valid <= 1'b0;
                acc_cnt    <= '0;
                pkt_cnt    <= '0;
                over_q     <= 1'b0;
                sent_q     <= '0;
            end
        end
    end

`ifdef RNG_SUM_EN
    logic [31:0] sum_q;

    // Keep a running modulo-2^32 sum of every byte that enters the packer.
    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            sum_q <= '0;
        end else if (go_accepted) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + {24'h0, RAW_DATA};
        end
    end

    assign RNG_SUM_DATA = sum_q;
`else
    assign RNG_SUM_DATA = 32'h0;
`endif

endmodule

// File: doc/rng_stream.md
RNG_STREAM -- requirements
Module: rng_stream

Interface
REQ-001 SHALL have parameter FIFO_DEPTH_LOG2, default 2, log2 of the output word FIFO depth (4 entries).
REQ-002 SHALL have port AXIS_ACLK, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port AXIS_ARESETN, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port RNG_GO / RNG_STOP, input, 1 each, one-cycle start/stop pulses from the control-register block.
REQ-005 SHALL have port RNG_SEND_BYTES, input, 32, byte limit per run; 0 means unlimited.
REQ-006 SHALL have port RNG_DMA_BYTES, input, 32, TLAST packet size in bytes, multiple of 4; 0 means no packet boundaries.
REQ-007 SHALL have port RAW_VALID / RAW_DATA, input, 1 / 8, one entropy byte per RAW_VALID cycle, no backpressure.
REQ-008 SHALL have port RNG_RUN / RNG_OVER, output, 1 each, run status and sticky overflow flag.
REQ-009 SHALL have port RNG_SENT_BYTES / RNG_SUM_DATA, output, 32 each, bytes transferred on the stream and running byte sum.
REQ-010 SHALL have ports AXIS_TDATA (output, 32), AXIS_TKEEP (output, 4), AXIS_TLAST (output, 1), AXIS_TVALID (output, 1) and AXIS_TREADY (input, 1), forming the AXI4-Stream master.

Function
REQ-011 SHALL implement states IDLE, RUN and FLUSH; RNG_RUN is 1 in RUN and FLUSH.
REQ-012 SHALL, on RNG_GO in IDLE, clear RNG_SENT_BYTES, RNG_SUM_DATA, RNG_OVER, the packer and the accepted-byte counter, then enter RUN the next cycle; RNG_GO outside IDLE SHALL be ignored.
REQ-013 SHALL, in RUN, accept each RAW_VALID byte into a 4-byte packer, little-endian: first byte goes to TDATA[7:0].
REQ-014 SHALL move a completed word into a hold register; the hold word is pushed to the FIFO only when the next byte is accepted or at termination.
REQ-015 SHALL, on termination, push the hold word or partial packer word with last=1, and TKEEP set to the contiguous low-byte mask of valid bytes.
REQ-016 SHALL terminate (RUN to FLUSH) when the accepted-byte count equals a nonzero RNG_SEND_BYTES; that final byte is included and no further bytes are accepted.
REQ-017 SHALL terminate on RNG_STOP in RUN; a RAW_VALID in the same cycle SHALL be discarded.
REQ-018 SHALL treat RNG_GO and RNG_STOP in the same cycle as RNG_STOP.
REQ-019 SHALL, on RNG_STOP with zero bytes accepted, return to IDLE without any stream transfer.
REQ-020 SHALL mark a pushed word last=1 when, with RNG_DMA_BYTES nonzero, the cumulative pushed bytes reach a multiple of RNG_DMA_BYTES.
REQ-021 SHALL, in FLUSH, return to IDLE the cycle after the FIFO drains and the final TLAST beat completes.
REQ-022 SHALL use FIFO entries of {last, keep[3:0], data[31:0]}; AXIS_TVALID = FIFO not empty, and the outputs are driven from the FIFO head.
REQ-023 SHALL pop only on TVALID&TREADY; TDATA, TKEEP and TLAST SHALL stay stable while TVALID&~TREADY.
REQ-024 SHALL support simultaneous push and pop when the FIFO is full.
REQ-025 SHALL, on a required push with the FIFO full and no pop that cycle, drop the incoming byte, set RNG_OVER, and keep the packer and hold contents unchanged.
REQ-026 SHALL keep RNG_OVER sticky until the next accepted RNG_GO.
REQ-027 SHALL increment RNG_SENT_BYTES by popcount(TKEEP) on each transfer, wrapping modulo 2^32.
REQ-028 SHALL make RNG_SUM_DATA the modulo-2^32 sum of the zero-extended bytes accepted into the packer, updated the cycle after acceptance.
REQ-029 SHALL ignore RAW_VALID in IDLE and FLUSH.

Reset
REQ-030 SHALL, on AXIS_ARESETN=0 at a clock edge, force state IDLE.
REQ-031 SHALL, on reset, clear to 0: FIFO pointers, packer, hold, counters, RNG_RUN, RNG_OVER, RNG_SENT_BYTES, RNG_SUM_DATA, AXIS_TVALID, AXIS_TLAST and AXIS_TKEEP.
REQ-032 SHALL, on reset mid-transfer, deassert AXIS_TVALID the cycle after the reset edge and discard pending data.

Configuration
REQ-033 SHALL, with macro RNG_SUM_EN defined, implement the RNG_SUM_DATA accumulator per REQ-028.
REQ-034 SHALL, without RNG_SUM_EN, tie RNG_SUM_DATA to 0 and synthesize no adder; all other behaviour is identical.

Verification
REQ-035 SHALL cover: SEND_BYTES=10, DMA_BYTES=0, TREADY=1, bytes 0x01..0x0A -> three beats 0x04030201/F, 0x08070605/F, 0x00000A09/3 with TLAST on the third only; SENT_BYTES=10; SUM=55; RUN falls.
REQ-036 SHALL cover: SEND_BYTES=0, DMA_BYTES=8, 16 bytes then STOP -> four beats, TLAST on beats 2 and 4, SENT_BYTES=16.
REQ-037 SHALL cover: TREADY=0, RAW_VALID every cycle -> FIFO fills, RNG_OVER=1, no beat lost or altered once TREADY=1; the next GO clears RNG_OVER.
REQ-038 SHALL cover: GO then STOP with no RAW_VALID -> no TVALID, RUN 1 for one cycle then 0; simultaneous GO+STOP in IDLE -> stays IDLE.
REQ-039 SHALL cover: reset asserted with TVALID=1 and TREADY=0 -> TVALID=0 next cycle, all status outputs 0.
REQ-040 SHALL cover: build without RNG_SUM_EN, rerun REQ-035 -> identical stream, RNG_SUM_DATA=0.
